// File: rtl/conv3x3_pkg.sv
// Shared types and helpers for the 3x3 window former.
// Holds the FSM state encoding, the tap count and the flat-word slice offset helper.
package conv3x3_pkg;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int WIN_TAPS = 9;

  // Bit offset of window element (i, j) inside the flat window word.
  function automatic int tap_offset(input int width, input int i, input int j);
    return width * (3 * i + j);
  endfunction

endpackage

// File: rtl/conv3x3_window_former_line_buffer.sv
// One image-row delay line: returns the word written at the same column one row earlier.
// Read is the pre-write contents of the addressed slot, so tap and pixel line up on the accept.
module conv3x3_window_former_line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_en,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      mem[i_addr] <= i_data;
    end
  end

  assign o_data = mem[i_addr];

endmodule

// File: rtl/conv3x3_window_former.sv
// Forms valid-mode 3x3 neighbourhoods from a raster pixel stream using two cascaded row delays.
// A window is emitted one cycle after every accepted pixel whose neighbourhood lies fully inside the frame.
module conv3x3_window_former
  import conv3x3_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                        i_clk,
  input  logic                        i_resetn,
  input  logic                        i_px_valid,
  input  logic [WIDTH-1:0]            i_px_data,
  output logic                        o_win_valid,
  output logic [WIN_TAPS*WIDTH-1:0]   o_win_data,
  output logic                        o_win_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]          col_reg;
  logic [ROW_W-1:0]          row_reg;
  state_t                    state_reg;
  state_t                    state_next;
  logic                      col_end;
  logic                      frame_end;
  logic                      emit;
  logic                      last_now;
  logic [WIDTH-1:0]          tap0;
  logic [WIDTH-1:0]          tap1;
  logic [WIDTH-1:0]          tap2;
  logic [WIDTH-1:0]          win_reg  [3][3];
  logic [WIDTH-1:0]          win_next [3][3];
  logic [WIN_TAPS*WIDTH-1:0] win_flat;

  assign tap0      = i_px_data;
  assign col_end   = (col_reg == COL_MAX);
  assign frame_end = col_end && (row_reg == ROW_MAX);

  // Cascade: row r-1 comes out of the first delay and feeds the second to give row r-2.
  conv3x3_window_former_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (WIDTH)
  ) u_line0 (
    .i_clk  (i_clk),
    .i_en   (i_px_valid),
    .i_addr (col_reg),
    .i_data (tap0),
    .o_data (tap1)
  );

  conv3x3_window_former_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (WIDTH)
  ) u_line1 (
    .i_clk  (i_clk),
    .i_en   (i_px_valid),
    .i_addr (col_reg),
    .i_data (tap1),
    .o_data (tap2)
  );

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (i_px_valid) begin
      if (col_end) begin
        col_reg <= '0;
        row_reg <= (row_reg == ROW_MAX) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_reg <= S_FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FILL: if (i_px_valid && col_end && (row_reg == ROW_W'(1))) state_next = S_RUN;
      S_RUN:  if (i_px_valid && frame_end) state_next = S_FILL;
      default: state_next = S_FILL;
    endcase
  end

  // Column gate hides the left-edge columns still holding the previous row's tail.
  always_comb begin
    emit     = i_px_valid && (state_reg == S_RUN) && (col_reg >= COL_W'(2));
    last_now = emit && frame_end;
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_next[i][0] = win_reg[i][1];
      win_next[i][1] = win_reg[i][2];
    end
    win_next[0][2] = tap2;
    win_next[1][2] = tap1;
    win_next[2][2] = tap0;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      for (genvar gj = 0; gj < 3; gj++) begin : g_col
        assign win_flat[tap_offset(WIDTH, gi, gj) +: WIDTH] = win_next[gi][gj];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_reg[i][j] <= '0;
        end
      end
    end else if (i_px_valid) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_reg[i][j] <= win_next[i][j];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_win_valid <= 1'b0;
      o_win_last  <= 1'b0;
      o_win_data  <= '0;
    end else begin
      o_win_valid <= emit;
      o_win_last  <= last_now;
      if (emit) begin
        o_win_data <= win_flat;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_window_former.sv
// Self-checking bench for conv3x3_window_former on a 4x4 image of 8-bit pixels.
// Table-driven frame checks plus a scoreboard for gapped, back-to-back, reset and stall sequences.
module tb_conv3x3_window_former;

  localparam int W  = 8;
  localparam int IW = 4;
  localparam int IH = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          px_valid = 1'b0;
  logic [W-1:0]  px_data = '0;
  logic          win_valid;
  logic [9*W-1:0] win_data;
  logic          win_last;

  conv3x3_window_former #(
    .WIDTH (W),
    .IMG_W (IW),
    .IMG_H (IH)
  ) dut (
    .i_clk       (clk),
    .i_resetn    (resetn),
    .i_px_valid  (px_valid),
    .i_px_data   (px_data),
    .o_win_valid (win_valid),
    .o_win_data  (win_data),
    .o_win_last  (win_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  px;
    logic        exp_valid;
    logic        exp_last;
    logic [71:0] exp_data;
  } vec_t;

  typedef struct {
    logic [71:0] data;
    logic        last;
    int          due;
  } exp_t;

  vec_t       tbl [16];
  exp_t       sb_q [$];
  exp_t       mon_item;
  int         checks = 0;
  int         errors = 0;
  int         mcyc   = 0;
  bit         sb_en  = 1'b0;
  logic [7:0] fb [4][4];
  int         mr = 0;
  int         mc = 0;

  // Scoreboard monitor: every window must match the queue head and arrive on its due cycle.
  always begin
    @(posedge clk);
    #1;
    mcyc++;
    if (sb_en) begin
      while (sb_q.size() > 0 && sb_q[0].due < mcyc) begin
        checks++; errors++;
        $display("FAIL missed_window: no o_win_valid at cycle %0d, required window %h", sb_q[0].due, sb_q[0].data);
        void'(sb_q.pop_front());
      end
      if (win_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got valid with data %h at cycle %0d, required none", win_data, mcyc);
        end else begin
          mon_item = sb_q.pop_front();
          if (mon_item.due != mcyc || mon_item.data != win_data || mon_item.last != win_last) begin
            errors++;
            $display("FAIL sb_window: got cyc=%0d data=%h last=%b, required cyc=%0d data=%h last=%b",
                     mcyc, win_data, win_last, mon_item.due, mon_item.data, mon_item.last);
          end else begin
            $display("window ok: cyc=%0d data=%h last=%b", mcyc, win_data, win_last);
          end
        end
      end
    end
  end

  task automatic model_accept(input logic [7:0] val);
    exp_t e;
    fb[mr][mc] = val;
    if (mr >= 2 && mc >= 2) begin
      e.data = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.data[8*(3*i+j) +: 8] = fb[mr-2+i][mc-2+j];
      e.last = (mr == IH-1) && (mc == IW-1);
      e.due  = mcyc + 1;
      sb_q.push_back(e);
    end
    if (mc == IW-1) begin
      mc = 0;
      mr = (mr == IH-1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic drive_px(input logic [7:0] val);
    @(negedge clk);
    px_valid = 1'b1;
    px_data  = val;
    if (sb_en) model_accept(val);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      px_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int gap, input logic [7:0] off);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        drive_px(8'(4*r + c) + off);
        if (gap > 0) idle(gap);
      end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_word(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic run_table_frame(input string tag);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      px_valid = 1'b1;
      px_data  = tbl[k].px;
      @(posedge clk);
      #1;
      check_bit ({tag, "_valid"}, win_valid, tbl[k].exp_valid);
      check_bit ({tag, "_last"},  win_last,  tbl[k].exp_last);
      check_word({tag, "_data"},  win_data,  tbl[k].exp_data);
      $display("%s px=%0d valid=%b last=%b data=%h", tag, tbl[k].px, win_valid, win_last, win_data);
    end
    idle(1);
  endtask

  initial begin
    logic [71:0] w10, w11, w14, w15;
    w10 = {8'd10, 8'd9,  8'd8,  8'd6,  8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    w11 = {8'd11, 8'd10, 8'd9,  8'd7,  8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
    w14 = {8'd14, 8'd13, 8'd12, 8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4};
    w15 = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
    for (int k = 0; k < 16; k++) begin
      tbl[k].px        = 8'(k);
      tbl[k].exp_valid = (k == 10 || k == 11 || k == 14 || k == 15);
      tbl[k].exp_last  = (k == 15);
      tbl[k].exp_data  = (k < 10) ? 72'd0 : (k < 11) ? w10 : (k < 14) ? w11 : (k < 15) ? w14 : w15;
    end

    // Reset state
    @(posedge clk);
    #1;
    check_bit ("reset_valid", win_valid, 1'b0);
    check_bit ("reset_last",  win_last,  1'b0);
    check_word("reset_data",  win_data,  72'd0);
    $display("reset: valid=%b last=%b data=%h", win_valid, win_last, win_data);
    @(negedge clk);
    resetn = 1'b1;

    run_table_frame("frame1");

    // Gapped frame, then two back-to-back frames with distinct contents
    sb_en = 1'b1;
    mr = 0; mc = 0;
    send_frame(2, 8'h00);
    idle(1);
    send_frame(0, 8'h00);
    send_frame(0, 8'h80);
    idle(3);

    // Asynchronous reset after 7 pixels of a new frame
    for (int k = 0; k < 7; k++) drive_px(8'(k) + 8'h40);
    @(negedge clk);
    px_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_bit ("async_reset_valid", win_valid, 1'b0);
    check_bit ("async_reset_last",  win_last,  1'b0);
    check_word("async_reset_data",  win_data,  72'd0);
    $display("mid-frame reset: valid=%b last=%b data=%h", win_valid, win_last, win_data);
    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_before_reset: got %0d queued windows, required 0", sb_q.size());
    end
    sb_en = 1'b0;
    sb_q.delete();
    mr = 0; mc = 0;
    @(negedge clk);
    resetn = 1'b1;

    run_table_frame("after_reset");

    // Partial frame then a long stall: no window may appear
    sb_en = 1'b1;
    for (int k = 0; k < 10; k++) drive_px(8'(k));
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      px_valid = 1'b0;
      check_bit("stall_valid", win_valid, 1'b0);
    end
    $display("stall: 20 idle cycles observed, valid=%b", win_valid);

    idle(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_windows: got %0d queued windows, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
